// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, R/W bit encoding and the default codec address.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StReg,
    StRegAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StIgnore
  } i2c_state_e;

  localparam logic       I2C_RW_WRITE     = 1'b0;
  localparam logic       I2C_RW_READ      = 1'b1;
  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h1A;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with an extra registered stage for SCL edge and START/STOP detection.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  // Reset to the idle bus level so leaving reset never produces a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target: 7-bit address match, register-pointer writes delivered on a valid/ready stream,
// auto-incrementing reads from an external register map. No clock stretching.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = I2C_DEFAULT_ADDR,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i2c_scl,
  input  logic       i2c_sda_in,
  output logic       i2c_sda_oe,
  output logic [7:0] wr_reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [7:0] rd_reg_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       overrun
);

  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  i2c_state_e state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic [7:0] ptr_q;
  logic       rw_q;
  logic       ack_q;
  logic       sda_oe_q;
  logic       busy_q;
  logic       wr_valid_q;
  logic [7:0] wr_reg_addr_q;
  logic [7:0] wr_data_q;
  logic       overrun_q;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (i2c_scl),
    .sda_i     (i2c_sda_in),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_det),
    .stop_o    (stop_det)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      ptr_q         <= '0;
      rw_q          <= I2C_RW_WRITE;
      ack_q         <= 1'b0;
      sda_oe_q      <= 1'b0;
      busy_q        <= 1'b0;
      wr_valid_q    <= 1'b0;
      wr_reg_addr_q <= '0;
      wr_data_q     <= '0;
      overrun_q     <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (wr_valid_q && wr_ready) wr_valid_q <= 1'b0;

      if (stop_det) begin
        state_q  <= StIdle;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
        ack_q    <= 1'b0;
      end else if (start_det) begin
        state_q   <= StAddr;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        ack_q     <= 1'b0;
      end else begin
        unique case (state_q)
          StAddr: if (scl_rise) begin
            shift_q   <= {shift_q[6:0], sda_s};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (shift_q[6:0] == TARGET_ADDR) begin
                busy_q  <= 1'b1;
                rw_q    <= sda_s;
                state_q <= StAddrAck;
              end else begin
                state_q <= StIgnore;
              end
            end
          end
          // First fall drives the ACK, second fall ends it.
          StAddrAck: if (scl_fall) begin
            bit_cnt_q <= '0;
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
            end else if (rw_q == I2C_RW_READ) begin
              shift_q  <= rd_data;
              sda_oe_q <= ~rd_data[7];
              state_q  <= StRdata;
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= StReg;
            end
          end
          StReg: if (scl_rise) begin
            shift_q   <= {shift_q[6:0], sda_s};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ptr_q   <= {shift_q[6:0], sda_s};
              state_q <= StRegAck;
            end
          end
          StRegAck, StWdataAck: if (scl_fall) begin
            bit_cnt_q <= '0;
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= StWdata;
            end
          end
          StWdata: if (scl_rise) begin
            shift_q   <= {shift_q[6:0], sda_s};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (!wr_valid_q) begin
                wr_reg_addr_q <= ptr_q;
                wr_data_q     <= {shift_q[6:0], sda_s};
                wr_valid_q    <= 1'b1;
                ptr_q         <= ptr_q + 8'd1;
                state_q       <= StWdataAck;
              end else begin
                overrun_q <= 1'b1;
                state_q   <= StIgnore;
              end
            end
          end
          StRdata: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_q <= StRdataAck;
            end else if (scl_fall) begin
              shift_q  <= {shift_q[6:0], 1'b0};
              sda_oe_q <= ~shift_q[6];
            end
          end
          // Fall after bit 8 releases SDA; the master's ACK arms a reload on the following fall.
          StRdataAck: begin
            if (scl_rise) begin
              if (!sda_s) begin
                ptr_q <= ptr_q + 8'd1;
                ack_q <= 1'b1;
              end else begin
                state_q <= StIgnore;
              end
            end else if (scl_fall) begin
              if (ack_q) begin
                shift_q   <= rd_data;
                sda_oe_q  <= ~rd_data[7];
                ack_q     <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= StRdata;
              end else begin
                sda_oe_q <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign i2c_sda_oe  = sda_oe_q;
  assign wr_reg_addr = wr_reg_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_valid    = wr_valid_q;
  assign rd_reg_addr = ptr_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: an in-bench I2C master drives SCL/SDA open-drain style.
module tb_i2c_target;

  localparam int T = 8;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic       wr_ready = 1'b0;
  logic       sda_line;
  logic       i2c_sda_oe;
  logic       wr_valid;
  logic       busy;
  logic       overrun;
  logic [7:0] wr_reg_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_reg_addr;
  logic [7:0] rd_data;

  int         checks = 0;
  int         errors = 0;
  int         hs_count = 0;
  int         ov_count = 0;
  int         oe_count = 0;
  logic [7:0] hs_addr = 8'h00;
  logic [7:0] hs_data = 8'h00;

  always #5 clk = ~clk;

  assign sda_line = ~(m_low | i2c_sda_oe);
  assign rd_data  = 8'hA0 + rd_reg_addr;

  i2c_target dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i2c_scl    (scl),
    .i2c_sda_in (sda_line),
    .i2c_sda_oe (i2c_sda_oe),
    .wr_reg_addr(wr_reg_addr),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .rd_reg_addr(rd_reg_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .overrun    (overrun)
  );

  always @(posedge clk) begin
    if (wr_valid && wr_ready) begin
      hs_count <= hs_count + 1;
      hs_addr  <= wr_reg_addr;
      hs_data  <= wr_data;
    end
    if (overrun) ov_count <= ov_count + 1;
    if (i2c_sda_oe) oe_count <= oe_count + 1;
  end

  task automatic wait_t();
    repeat (T) @(negedge clk);
  endtask

  task automatic bus_start();
    m_low = 1'b0; wait_t();
    scl = 1'b1;   wait_t();
    m_low = 1'b1; wait_t();
    scl = 1'b0;   wait_t();
  endtask

  task automatic bus_stop();
    m_low = 1'b1; wait_t();
    scl = 1'b1;   wait_t();
    m_low = 1'b0; wait_t();
    wait_t();
  endtask

  task automatic clock_bit(input logic drive, output logic sampled);
    m_low = ~drive; wait_t();
    scl = 1'b1;     wait_t();
    sampled = sda_line;
    wait_t();
    scl = 1'b0;     wait_t();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(~master_ack, s);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (i2c_sda_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", i2c_sda_oe); end
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got %b want 0", wr_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (rd_reg_addr !== 8'h00) begin errors++; $display("FAIL reset_ptr got %h want 00", rd_reg_addr); end
    checks++; if (wr_reg_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr got %h want 00", wr_reg_addr); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
  endtask

  task automatic test_write(input logic [7:0] reg_a, input logic [7:0] dat);
    logic a0, a1, a2;
    int   hs0;
    wr_ready = 1'b1;
    hs0 = hs_count;
    bus_start();
    send_byte(8'h34, a0);
    send_byte(reg_a, a1);
    send_byte(dat, a2);
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL write_acks got %b want 111", {a0, a1, a2}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy got %b want 1", busy); end
    bus_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop got %b want 0", busy); end
    checks++; if (hs_count - hs0 !== 1) begin errors++; $display("FAIL write_count got %0d want 1", hs_count - hs0); end
    checks++; if (hs_addr !== reg_a) begin errors++; $display("FAIL write_addr got %h want %h", hs_addr, reg_a); end
    checks++; if (hs_data !== dat) begin errors++; $display("FAIL write_data got %h want %h", hs_data, dat); end
    checks++; if (rd_reg_addr !== reg_a + 8'd1) begin errors++; $display("FAIL write_ptr got %h want %h", rd_reg_addr, reg_a + 8'd1); end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    int   oe0, hs0;
    oe0 = oe_count;
    hs0 = hs_count;
    bus_start();
    send_byte(8'h36, a0);
    send_byte(8'h07, a1);
    checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL mismatch_addr_ack got %b want 0", a0); end
    checks++; if (a1 !== 1'b0) begin errors++; $display("FAIL mismatch_data_ack got %b want 0", a1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mismatch_busy got %b want 0", busy); end
    bus_stop();
    checks++; if (oe_count !== oe0) begin errors++; $display("FAIL mismatch_oe_cycles got %0d want %0d", oe_count, oe0); end
    checks++; if (hs_count !== hs0) begin errors++; $display("FAIL mismatch_writes got %0d want %0d", hs_count, hs0); end
  endtask

  task automatic test_overrun();
    logic a0, a1, a2, a3;
    int   ov0;
    wr_ready = 1'b0;
    bus_start();
    send_byte(8'h34, a0);
    send_byte(8'hFF, a1);
    send_byte(8'h11, a2);
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL ovr_acks got %b want 111", {a0, a1, a2}); end
    checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", wr_valid); end
    checks++; if (wr_reg_addr !== 8'hFF) begin errors++; $display("FAIL ovr_wr_addr got %h want ff", wr_reg_addr); end
    checks++; if (rd_reg_addr !== 8'h00) begin errors++; $display("FAIL ovr_ptr_wrap got %h want 00", rd_reg_addr); end
    ov0 = ov_count;
    send_byte(8'h22, a3);
    checks++; if (a3 !== 1'b0) begin errors++; $display("FAIL ovr_nack got %b want 0", a3); end
    checks++; if (ov_count - ov0 !== 1) begin errors++; $display("FAIL ovr_pulses got %0d want 1", ov_count - ov0); end
    checks++; if (rd_reg_addr !== 8'h00) begin errors++; $display("FAIL ovr_ptr_hold got %h want 00", rd_reg_addr); end
    checks++; if (wr_data !== 8'h11) begin errors++; $display("FAIL ovr_wr_data got %h want 11", wr_data); end
    bus_stop();
    wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got %b want 0", wr_valid); end
  endtask

  task automatic test_read();
    logic       a0, a1, a2;
    logic [7:0] b0, b1;
    bus_start();
    send_byte(8'h34, a0);
    send_byte(8'h10, a1);
    bus_start();
    send_byte(8'h35, a2);
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL read_acks got %b want 111", {a0, a1, a2}); end
    read_byte(1'b1, b0);
    read_byte(1'b0, b1);
    checks++; if (b0 !== 8'hB0) begin errors++; $display("FAIL read_byte0 got %h want b0", b0); end
    checks++; if (b1 !== 8'hB1) begin errors++; $display("FAIL read_byte1 got %h want b1", b1); end
    checks++; if (i2c_sda_oe !== 1'b0) begin errors++; $display("FAIL read_release got %b want 0", i2c_sda_oe); end
    checks++; if (rd_reg_addr !== 8'h11) begin errors++; $display("FAIL read_ptr got %h want 11", rd_reg_addr); end
    bus_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic       a0, a1, s;
    logic [7:0] d;
    wr_ready = 1'b0;
    d = 8'h55;
    bus_start();
    send_byte(8'h34, a0);
    send_byte(8'h20, a1);
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    m_low = 1'b0;
    for (int i = 0; i < 40 && !i2c_sda_oe; i++) @(negedge clk);
    checks++; if (i2c_sda_oe !== 1'b1) begin errors++; $display("FAIL rstmid_ack_drive got %b want 1", i2c_sda_oe); end
    checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid_pre got %b want 1", wr_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (i2c_sda_oe !== 1'b0) begin errors++; $display("FAIL rstmid_oe got %b want 0", i2c_sda_oe); end
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", wr_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_t();
    scl = 1'b1;
    wait_t();
    wr_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write(8'h07, 8'h5A);
    test_mismatch();
    test_overrun();
    test_read();
    test_reset_mid();
    test_write(8'h04, 8'hC3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
